spiflash_responder: RTL and testbench

SPIFLASH_RESPONDER -- requirements
Module: spiflash_responder

---
 rtl/spiflash_pkg.sv | 34 +++
 rtl/spi_pin_sync.sv | 50 +++++
 rtl/spiflash_responder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_spiflash_responder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiflash_pkg.sv
// Shared opcodes, FSM state encoding and JEDEC ID byte
// selection for the SPI flash read responder.
package spiflash_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_RES  = 8'hAB;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_ID,
      ST_IGNORE
   } state_e;

   // ID bytes go out MSB first; past the third byte the
   // line idles at all-ones.
   function automatic logic [7:0] id_byte(
      input logic [23:0] id,
      input logic [1:0]  idx
   );
      logic [7:0] b;
      unique case (idx)
         2'd0:    b = id[23:16];
         2'd1:    b = id[15:8];
         2'd2:    b = id[7:0];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for csb/sck/mosi plus edge detect.
// Ports: clk, reset in; csb_i/sck_i/mosi_i raw pins in;
//   csb_o/mosi_o synchronized levels; sck_rise_o,
//   sck_fall_o, csb_fall_o, csb_rise_o one-clk pulses.
module spi_pin_sync (
   input  logic clk,
   input  logic reset,
   input  logic csb_i,
   input  logic sck_i,
   input  logic mosi_i,
   output logic csb_o,
   output logic mosi_o,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic csb_fall_o,
   output logic csb_rise_o
);

   // bit order in all vectors: {csb, sck, mosi}
   logic [2:0] meta_q, meta_d;
   logic [2:0] sync_q, sync_d;
   // previous synchronized {csb, sck} for edge detect
   logic [1:0] prev_q, prev_d;

   always_comb begin
      meta_d = {csb_i, sck_i, mosi_i};
      sync_d = meta_q;
      prev_d = sync_q[2:1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 3'b100;
         sync_q <= 3'b100;
         prev_q <= 2'b10;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign csb_o      = sync_q[2];
   assign mosi_o     = sync_q[0];
   assign sck_rise_o =  sync_q[1] & ~prev_q[0];
   assign sck_fall_o = ~sync_q[1] &  prev_q[0];
   assign csb_fall_o = ~sync_q[2] &  prev_q[1];
   assign csb_rise_o =  sync_q[2] & ~prev_q[1];

endmodule

// File: rtl/spiflash_responder.sv
// SPI flash target answering READ (0x03) and RDID (0x9F)
// from a byte-wide memory request port.
// Ports: clk/reset; spi_csb, spi_clk, spi_mosi pins in;
//   spi_miso/spi_miso_oe out; mem_valid/mem_addr request,
//   mem_ready/mem_rdata response; underrun sticky flag.
module spiflash_responder #(
   parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
   parameter int unsigned ADDR_BITS = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spi_csb,
   input  logic                 spi_clk,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic                 mem_valid,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic                 mem_ready,
   input  logic [7:0]           mem_rdata,
   output logic                 underrun
);

   import spiflash_pkg::*;

   localparam int RXW = (ADDR_BITS > 8) ? ADDR_BITS : 8;
   localparam int CW  = $clog2(RXW) + 1;

   logic csb_s, mosi_s;
   logic sck_rise, sck_fall, csb_fall, csb_rise;

   spi_pin_sync u_sync (
      .clk        (clk),
      .reset      (reset),
      .csb_i      (spi_csb),
      .sck_i      (spi_clk),
      .mosi_i     (spi_mosi),
      .csb_o      (csb_s),
      .mosi_o     (mosi_s),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .csb_fall_o (csb_fall),
      .csb_rise_o (csb_rise)
   );

   state_e               state_q, state_d;
   logic [RXW-2:0]       rx_q, rx_d;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]           tx_q, tx_d;
   logic [2:0]           tx_cnt_q, tx_cnt_d;
   logic                 miso_q, miso_d;
   logic                 oe_q, oe_d;
   logic [1:0]           id_idx_q, id_idx_d;
   logic [7:0]           buf_q, buf_d;
   logic                 buf_valid_q, buf_valid_d;
   logic                 req_due_q, req_due_d;
   logic                 drop_q, drop_d;
   logic [ADDR_BITS-1:0] next_addr_q, next_addr_d;
   logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
   logic                 mem_valid_q, mem_valid_d;
   logic                 underrun_q, underrun_d;
   logic                 armed_q, armed_d;
   logic [1:0]           settle_q, settle_d;

   logic [RXW-1:0]       rx_next;
   logic [ADDR_BITS-1:0] rx_addr;
   logic                 handshake, got, issue;
   logic                 load, shift_en;
   logic [7:0]           load_byte;

   always_comb begin
      state_d     = state_q;
      rx_d        = rx_q;
      bit_cnt_d   = bit_cnt_q;
      tx_d        = tx_q;
      tx_cnt_d    = tx_cnt_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      id_idx_d    = id_idx_q;
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      req_due_d   = req_due_q;
      drop_d      = drop_q;
      next_addr_d = next_addr_q;
      mem_addr_d  = mem_addr_q;
      mem_valid_d = mem_valid_q;
      underrun_d  = underrun_q;
      armed_d     = armed_q;
      settle_d    = settle_q;
      rx_next     = {rx_q, mosi_s};
      rx_addr     = rx_next[ADDR_BITS-1:0];
      handshake   = mem_valid_q & mem_ready;
      got         = 1'b0;
      issue       = 1'b0;
      load        = 1'b0;
      shift_en    = 1'b0;
      load_byte   = 8'hFF;

      // The synchronizers hold csb=1 through reset, so a
      // real high on the pin is only trusted once the
      // pipeline has refilled from the pad.
      if (settle_q != 2'd3)
         settle_d = settle_q + 2'd1;
      if (settle_q[1] && csb_s)
         armed_d = 1'b1;

      if (handshake) begin
         mem_valid_d = 1'b0;
         drop_d      = 1'b0;
         got = ~drop_q & ~csb_s & (state_q == ST_DATA);
      end

      if (req_due_q && !mem_valid_q && !csb_s) begin
         issue       = 1'b1;
         mem_valid_d = 1'b1;
         mem_addr_d  = next_addr_q;
         next_addr_d = next_addr_q + ADDR_BITS'(1);
         req_due_d   = 1'b0;
      end

      if (csb_s) begin
         state_d     = ST_IDLE;
         oe_d        = 1'b0;
         req_due_d   = 1'b0;
         buf_valid_d = 1'b0;
         // an in-flight request must finish on the bus,
         // but its byte belongs to a dead transfer
         if (csb_rise && mem_valid_q && !mem_ready)
            drop_d = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (csb_fall && armed_q) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = '0;
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  rx_d      = rx_next[RXW-2:0];
                  bit_cnt_d = bit_cnt_q + CW'(1);
                  if (bit_cnt_q == CW'(7)) begin
                     bit_cnt_d = '0;
                     tx_cnt_d  = '0;
                     id_idx_d  = '0;
                     unique case (rx_next[7:0])
                        OP_READ: state_d = ST_ADDR;
                        OP_RDID: state_d = ST_ID;
                        OP_RES:  state_d = ST_IGNORE;
                        default: state_d = ST_IGNORE;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (sck_rise) begin
                  rx_d      = rx_next[RXW-2:0];
                  bit_cnt_d = bit_cnt_q + CW'(1);
                  if (bit_cnt_q == CW'(ADDR_BITS - 1)) begin
                     state_d = ST_DATA;
                     if (!mem_valid_q) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = rx_addr;
                        next_addr_d = rx_addr + ADDR_BITS'(1);
                     end else begin
                        // old transfer's request still busy
                        req_due_d   = 1'b1;
                        next_addr_d = rx_addr;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (sck_fall) begin
                  if (tx_cnt_q == 3'd0) begin
                     load = 1'b1;
                     if (buf_valid_q) begin
                        load_byte   = buf_q;
                        buf_valid_d = 1'b0;
                     end else if (got) begin
                        load_byte = mem_rdata;
                        got       = 1'b0;
                     end else begin
                        underrun_d = 1'b1;
                        if (mem_valid_q && !handshake)
                           drop_d = 1'b1;
                     end
                     // A slot whose request never issued is
                     // skipped so addresses stay in step
                     // with byte position.
                     if (req_due_q && !issue)
                        next_addr_d = next_addr_q + ADDR_BITS'(1);
                     req_due_d = 1'b1;
                  end else begin
                     shift_en = 1'b1;
                  end
               end
            end
            ST_ID: begin
               if (sck_fall) begin
                  if (tx_cnt_q == 3'd0) begin
                     load      = 1'b1;
                     load_byte = id_byte(JEDEC_ID, id_idx_q);
                     if (id_idx_q != 2'd3)
                        id_idx_d = id_idx_q + 2'd1;
                  end else begin
                     shift_en = 1'b1;
                  end
               end
            end
            ST_IGNORE: begin
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (got) begin
         buf_d       = mem_rdata;
         buf_valid_d = 1'b1;
      end

      if (load) begin
         miso_d   = load_byte[7];
         tx_d     = {load_byte[6:0], 1'b0};
         tx_cnt_d = tx_cnt_q + 3'd1;
         oe_d     = 1'b1;
      end else if (shift_en) begin
         miso_d   = tx_q[7];
         tx_d     = {tx_q[6:0], 1'b0};
         tx_cnt_d = tx_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rx_q        <= '0;
         bit_cnt_q   <= '0;
         tx_q        <= '0;
         tx_cnt_q    <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         id_idx_q    <= '0;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         req_due_q   <= 1'b0;
         drop_q      <= 1'b0;
         next_addr_q <= '0;
         mem_addr_q  <= '0;
         mem_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
         armed_q     <= 1'b0;
         settle_q    <= '0;
      end else begin
         state_q     <= state_d;
         rx_q        <= rx_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_q        <= tx_d;
         tx_cnt_q    <= tx_cnt_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         id_idx_q    <= id_idx_d;
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
         req_due_q   <= req_due_d;
         drop_q      <= drop_d;
         next_addr_q <= next_addr_d;
         mem_addr_q  <= mem_addr_d;
         mem_valid_q <= mem_valid_d;
         underrun_q  <= underrun_d;
         armed_q     <= armed_d;
         settle_q    <= settle_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign mem_valid   = mem_valid_q;
   assign mem_addr    = mem_addr_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_spiflash_responder.sv
// Randomized bench for spiflash_responder: SPI master tasks,
// a latency-controlled memory and a byte-level model.
`timescale 1ns/1ps
module tb_spiflash_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_csb, spi_clk, spi_mosi;
   logic        spi_miso, spi_miso_oe;
   logic        mem_valid, mem_ready;
   logic [23:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        underrun;

   int          errors = 0;
   int          checks = 0;
   int          half_ns = 50;
   int          mem_lat = 1;
   bit          hold = 0;
   bit          mon = 0;
   bit          seen_oe, seen_valid;
   logic [23:0] req_log[$];
   logic [7:0]  rx_bytes[16];

   always #5 clk = ~clk;

   spiflash_responder dut (
      .clk         (clk),
      .reset       (reset),
      .spi_csb     (spi_csb),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .underrun    (underrun)
   );

   // memory: returns addr[7:0] mem_lat clocks after request
   initial begin
      int cnt;
      cnt = 0;
      mem_ready = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (mem_valid && !hold) begin
            cnt++;
            if (cnt >= mem_lat) begin
               mem_ready = 1'b1;
               mem_rdata = mem_addr[7:0];
               req_log.push_back(mem_addr);
               cnt = 0;
            end
         end else if (!mem_valid) begin
            cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon) begin
         if (spi_miso_oe) seen_oe = 1'b1;
         if (mem_valid) seen_valid = 1'b1;
      end
   end

   task automatic spi_bit(input logic b, output logic r);
      spi_mosi = b;
      #(half_ns);
      r = spi_miso;
      spi_clk = 1'b1;
      #(half_ns);
      spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx,
                           output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
   endtask

   task automatic spi_start();
      @(negedge clk);
      spi_clk = 1'b0;
      #(half_ns);
      spi_csb = 1'b0;
      #(half_ns);
   endtask

   task automatic spi_end();
      #(half_ns);
      spi_csb = 1'b1;
      #(half_ns);
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_xact(input logic [7:0] op,
                           input bit has_addr,
                           input logic [23:0] addr,
                           input int n);
      logic [7:0] d;
      spi_start();
      spi_byte(op, d);
      if (has_addr) begin
         spi_byte(addr[23:16], d);
         spi_byte(addr[15:8], d);
         spi_byte(addr[7:0], d);
      end
      for (int i = 0; i < n; i++) begin
         spi_byte(8'h00, d);
         rx_bytes[i] = d;
      end
      spi_end();
   endtask

   task automatic wait_mem_idle(input string tag);
      int k;
      k = 0;
      while (mem_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: mem_valid=%b want 0",
                  tag, mem_valid);
      end
   endtask

   task automatic check_read(input string tag,
                             input logic [23:0] addr,
                             input int n);
      logic [23:0] a;
      for (int i = 0; i < n; i++) begin
         a = addr + 24'(i);
         checks++;
         if (rx_bytes[i] !== a[7:0]) begin
            errors++;
            $display("FAIL %s byte%0d: got %h want %h",
                     tag, i, rx_bytes[i], a[7:0]);
         end
      end
   endtask

   task automatic check_idle_outs(input string tag);
      checks++;
      if ({mem_valid, mem_addr, spi_miso, spi_miso_oe,
           underrun} !== 28'h0) begin
         errors++;
         $display("FAIL %s: v=%b a=%h m=%b oe=%b u=%b want 0",
                  tag, mem_valid, mem_addr, spi_miso,
                  spi_miso_oe, underrun);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outs("reset");
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_read_basic();
      half_ns = 50;
      mem_lat = 1;
      req_log.delete();
      spi_xact(8'h03, 1, 24'h000010, 4);
      wait_mem_idle("basic");
      check_read("basic", 24'h000010, 4);
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL basic underrun: got %b want 0",
                  underrun);
      end
   endtask

   task automatic test_read_wrap();
      logic [23:0] exp;
      req_log.delete();
      spi_xact(8'h03, 1, 24'hFFFFFE, 4);
      wait_mem_idle("wrap");
      check_read("wrap", 24'hFFFFFE, 4);
      checks++;
      if (req_log.size() < 4) begin
         errors++;
         $display("FAIL wrap reqs: got %0d want >=4",
                  req_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp = 24'hFFFFFE + 24'(i);
            checks++;
            if (req_log[i] !== exp) begin
               errors++;
               $display("FAIL wrap req%0d: got %h want %h",
                        i, req_log[i], exp);
            end
         end
      end
   endtask

   task automatic test_random_reads();
      logic [23:0] a;
      int n;
      for (int t = 0; t < 6; t++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 5);
         mem_lat = $urandom_range(1, 3);
         spi_xact(8'h03, 1, a, n);
         wait_mem_idle("rand");
         check_read("rand", a, n);
      end
      mem_lat = 1;
   endtask

   task automatic test_jedec();
      logic [7:0] exp[5];
      exp = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};
      seen_valid = 1'b0;
      mon = 1'b1;
      spi_xact(8'h9F, 0, 24'h0, 5);
      mon = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rx_bytes[i] !== exp[i]) begin
            errors++;
            $display("FAIL jedec byte%0d: got %h want %h",
                     i, rx_bytes[i], exp[i]);
         end
      end
      checks++;
      if (seen_valid !== 1'b0) begin
         errors++;
         $display("FAIL jedec mem_valid: got 1 want 0");
      end
   endtask

   task automatic test_ignore();
      seen_oe = 1'b0;
      seen_valid = 1'b0;
      mon = 1'b1;
      spi_xact(8'hAB, 0, 24'h0, 3);
      mon = 1'b0;
      checks++;
      if ({seen_oe, seen_valid} !== 2'b00) begin
         errors++;
         $display("FAIL ignore: oe=%b valid=%b want 0 0",
                  seen_oe, seen_valid);
      end
   endtask

   task automatic test_csb_abort();
      logic r;
      logic [7:0] d;
      int k;
      spi_start();
      spi_byte(8'h03, d);
      spi_byte(8'h00, d);
      spi_byte(8'h02, d);
      spi_byte(8'h00, d);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
      hold = 1'b1;
      for (int i = 0; i < 8; i++) spi_bit(1'b0, r);
      spi_end();
      repeat (10) @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort held: mem_valid=%b want 1",
                  mem_valid);
      end
      checks++;
      if (spi_miso_oe !== 1'b0) begin
         errors++;
         $display("FAIL abort oe: got %b want 0",
                  spi_miso_oe);
      end
      hold = 1'b0;
      wait_mem_idle("abort");
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_valid) k++;
      end
      checks++;
      if (k != 0) begin
         errors++;
         $display("FAIL abort reissue: got %0d want 0", k);
      end
      spi_xact(8'h03, 1, 24'h000100, 2);
      wait_mem_idle("after_abort");
      check_read("after_abort", 24'h000100, 2);
   endtask

   task automatic test_underrun();
      bit ff_seen;
      half_ns = 40;
      mem_lat = 40;
      spi_xact(8'h03, 1, 24'h000020, 4);
      wait_mem_idle("underrun");
      ff_seen = 1'b0;
      for (int i = 0; i < 4; i++)
         if (rx_bytes[i] == 8'hFF) ff_seen = 1'b1;
      checks++;
      if (!ff_seen) begin
         errors++;
         $display("FAIL underrun ff: got %h %h %h %h want FF",
                  rx_bytes[0], rx_bytes[1], rx_bytes[2],
                  rx_bytes[3]);
      end
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun flag: got %b want 1",
                  underrun);
      end
      half_ns = 50;
      mem_lat = 1;
      spi_xact(8'h03, 1, 24'h000030, 2);
      wait_mem_idle("post_underrun");
      check_read("post_underrun", 24'h000030, 2);
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun sticky: got %b want 1",
                  underrun);
      end
   endtask

   task automatic test_reset_in_addr();
      logic [7:0] d;
      logic [23:0] a;
      spi_start();
      spi_byte(8'h03, d);
      spi_byte(8'h12, d);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle_outs("reset_in_addr");
      reset = 1'b0;
      seen_oe = 1'b0;
      seen_valid = 1'b0;
      mon = 1'b1;
      spi_byte(8'h34, d);
      spi_byte(8'h56, d);
      spi_byte(8'h00, d);
      spi_byte(8'h00, d);
      mon = 1'b0;
      checks++;
      if ({seen_oe, seen_valid} !== 2'b00) begin
         errors++;
         $display("FAIL rearm: oe=%b valid=%b want 0 0",
                  seen_oe, seen_valid);
      end
      spi_end();
      a = 24'($urandom);
      spi_xact(8'h03, 1, a, 3);
      wait_mem_idle("rearm_read");
      check_read("rearm_read", a, 3);
   endtask

   initial begin
      spi_csb = 1'b1;
      spi_clk = 1'b0;
      spi_mosi = 1'b0;
      test_reset();
      test_read_basic();
      test_read_wrap();
      test_random_reads();
      test_jedec();
      test_ignore();
      test_csb_abort();
      test_underrun();
      test_reset_in_addr();
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
